// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async_fifo read-side stream adapter.
package async_fifo_pkg;

    localparam int unsigned DEFAULT_PREFETCH_DEPTH = 3;

    localparam int unsigned BEAT_BITS = 32;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // One stream beat as seen on the m_valid/m_data pair.
    typedef struct packed {
        logic                 valid;
        logic [BEAT_BITS-1:0] data;
    } stream_beat_t;

endpackage

// File: rtl/prefetch_ring_buf.sv
// Small circular prefetch buffer: storage, head/tail pointers and occupancy.
module prefetch_ring_buf
    import async_fifo_pkg::*;
#(
    parameter int unsigned BITS  = 32,
    parameter int unsigned DEPTH = DEFAULT_PREFETCH_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [BITS-1:0]                 push_data,
    input  logic                            pop,
    input  logic                            clear,
    output logic [BITS-1:0]                 head_data,
    output logic [level_width(DEPTH)-1:0]   occ
);

    localparam int unsigned LW       = level_width(DEPTH);
    localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BITS-1:0]     mem [DEPTH];
    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;

    // Compare-and-reset so non-power-of-two depths wrap correctly.
    function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_data = mem[head];

    // Storage, pointer and occupancy update; clear discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            occ <= occ + LW'(push) - LW'(pop);
        end
    end

    // The issue logic guarantees a free slot for every arriving word.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !clear && occ == LW'(DEPTH)));

endmodule

// File: rtl/fifo_read_stream_adapter.sv
// Read-side adapter: pulls words from async_fifo and presents a valid/ready stream.
module fifo_read_stream_adapter
    import async_fifo_pkg::*;
#(
    parameter int unsigned BITS     = 32,
    parameter int unsigned DEPTH    = DEFAULT_PREFETCH_DEPTH,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                            read_clk,
    input  logic                            read_rst_n,
    output logic                            p_read_en,
    input  logic [BITS-1:0]                 p_read_data,
    input  logic                            p_read_empty,
    output logic                            m_valid,
    output logic [BITS-1:0]                 m_data,
    input  logic                            m_ready,
    input  logic                            flush,
    output logic [level_width(DEPTH)-1:0]   level,
    output logic [CNT_BITS-1:0]             words_out
);

    localparam int unsigned LW = level_width(DEPTH);

    logic          in_flight;
    logic          drop;
    logic          push;
    logic          pop;
    logic [LW-1:0] occ;
    logic [LW:0]   outstanding;

    // Issue a read only when a slot is reserved for it (buffered + in flight).
    always_comb begin
        outstanding = {1'b0, occ} + (LW + 1)'(in_flight);
        p_read_en   = read_rst_n && !p_read_empty && !flush &&
                      (outstanding < (LW + 1)'(DEPTH));
    end

    assign push    = in_flight && !drop && !flush;
    assign pop     = m_valid && m_ready;
    assign m_valid = (occ != '0);
    assign level   = occ;

    prefetch_ring_buf #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (read_clk),
        .rst_n     (read_rst_n),
        .push      (push),
        .push_data (p_read_data),
        .pop       (pop),
        .clear     (flush),
        .head_data (m_data),
        .occ       (occ)
    );

    // Track the outstanding FIFO read, the flush drop flag and delivered words.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            in_flight <= 1'b0;
            drop      <= 1'b0;
            words_out <= '0;
        end else begin
            in_flight <= p_read_en;
            drop      <= flush && in_flight;
            if (pop) begin
                words_out <= words_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Bench for fifo_read_stream_adapter: queue-based model plus directed scenarios.
module tb_fifo_read_stream_adapter;
    import async_fifo_pkg::*;

    localparam int unsigned DEPTH  = 3;
    localparam int unsigned LW     = level_width(DEPTH);
    localparam int unsigned DEPTH2 = 2;
    localparam int unsigned LW2    = level_width(DEPTH2);
    localparam int unsigned N2     = 32;

    logic          read_clk = 1'b0;
    logic          read_rst_n = 1'b0;
    logic          p_read_en;
    logic [31:0]   p_read_data = '0;
    logic          p_read_empty = 1'b1;
    logic          m_valid;
    logic [31:0]   m_data;
    logic          m_ready = 1'b0;
    logic          flush = 1'b0;
    logic [LW-1:0] level;
    logic [15:0]   words_out;

    logic           p2_read_en;
    logic [31:0]    p2_read_data = '0;
    logic           p2_read_empty = 1'b0;
    logic           m2_valid;
    logic [31:0]    m2_data;
    logic           m2_ready = 1'b1;
    logic           flush2 = 1'b0;
    logic [LW2-1:0] level2;
    logic [3:0]     words2;

    fifo_read_stream_adapter #(.BITS(32), .DEPTH(DEPTH), .CNT_BITS(16)) dut (
        .read_clk(read_clk), .read_rst_n(read_rst_n), .p_read_en(p_read_en),
        .p_read_data(p_read_data), .p_read_empty(p_read_empty), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .flush(flush), .level(level),
        .words_out(words_out));

    fifo_read_stream_adapter #(.BITS(32), .DEPTH(DEPTH2), .CNT_BITS(4)) dut2 (
        .read_clk(read_clk), .read_rst_n(read_rst_n), .p_read_en(p2_read_en),
        .p_read_data(p2_read_data), .p_read_empty(p2_read_empty), .m_valid(m2_valid),
        .m_data(m2_data), .m_ready(m2_ready), .flush(flush2), .level(level2),
        .words_out(words2));

    always #5 read_clk = ~read_clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench-side async_fifo contents; second source is simply words 1..N2.
    logic [31:0] fifo_q[$];
    int unsigned p2_next = 1;

    // Model: words read from the FIFO and not yet delivered or flushed.
    logic [31:0] model_q[$];
    logic [31:0] model2_q[$];
    bit          read_last = 0;
    bit          read2_last = 0;
    int unsigned exp_cnt = 0;
    int unsigned exp_cnt2 = 0;

    always @(negedge read_clk) begin
        int  exp_occ;
        bit  mv;
        if (!read_rst_n) begin
            chk("rst_p_read_en", p_read_en, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_level", level, 0);
            chk("rst_words_out", words_out, 0);
            chk("rst2_p_read_en", p2_read_en, 0);
            chk("rst2_m_valid", m2_valid, 0);
            model_q.delete();
            model2_q.delete();
            read_last  = 0;
            read2_last = 0;
            exp_cnt    = 0;
            exp_cnt2   = 0;
        end else begin
            // Main instance: a read in the previous cycle is still arriving.
            exp_occ = model_q.size() - int'(read_last);
            mv = (exp_occ != 0);
            if (p_read_empty) chk("read_when_empty", p_read_en, 0);
            chk("p_read_en", p_read_en,
                !p_read_empty && !flush && (model_q.size() < DEPTH));
            chk("level", level, exp_occ);
            chk("m_valid", m_valid, mv);
            if (mv) chk("m_data", m_data, model_q[0]);
            chk("words_out", words_out, 32'(16'(exp_cnt)));
            if (mv && m_ready) exp_cnt++;
            if (flush) model_q.delete();
            else if (mv && m_ready) void'(model_q.pop_front());
            read_last = p_read_en && (fifo_q.size() != 0);
            if (read_last) model_q.push_back(fifo_q[0]);

            // DEPTH=2 instance with a 4-bit counter.
            exp_occ = model2_q.size() - int'(read2_last);
            mv = (exp_occ != 0);
            if (p2_read_empty) chk("read_when_empty2", p2_read_en, 0);
            chk("level2", level2, exp_occ);
            chk("m2_valid", m2_valid, mv);
            if (mv) chk("m2_data", m2_data, model2_q[0]);
            chk("words2", words2, 32'(4'(exp_cnt2)));
            if (mv && m2_ready) begin
                exp_cnt2++;
                void'(model2_q.pop_front());
            end
            read2_last = p2_read_en && (p2_next <= N2);
            if (read2_last) model2_q.push_back(32'(p2_next));
        end
    end

    // Per-cycle driver bookkeeping.
    int unsigned cyc = 0;
    bit          last_rd = 0;
    bit          prev_rd = 0;
    bit          last_valid = 0;
    bit          last_beat = 0;
    logic [31:0] last_data = '0;

    task automatic cycle();
        bit rd;
        bit rd2;
        @(negedge read_clk);
        rd  = p_read_en && (fifo_q.size() != 0);
        rd2 = p2_read_en && (p2_next <= N2);
        prev_rd    = last_rd;
        last_rd    = rd;
        last_valid = m_valid;
        last_beat  = m_valid && m_ready;
        last_data  = m_data;
        @(posedge read_clk);
        #1;
        if (rd) p_read_data = fifo_q.pop_front();
        p_read_empty = (fifo_q.size() == 0);
        if (rd2) begin
            p2_read_data = 32'(p2_next);
            p2_next++;
        end
        p2_read_empty = (p2_next > N2);
        cyc++;
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        p_read_empty = 1'b0;
    endtask

    initial begin
        int unsigned k;
        int unsigned got;

        // Reset with a preloaded, non-empty FIFO.
        for (int unsigned i = 1; i <= 16; i++) push_word(32'(i));
        repeat (5) cycle();
        read_rst_n = 1'b1;
        m_ready    = 1'b1;

        // First cycle after release issues a read; data valid two cycles later.
        cycle();
        chk("rd_en_after_reset", 32'(last_rd), 1);
        k = 0;
        do begin
            cycle();
            k++;
        end while (!last_valid && k < 10);
        chk("first_valid_latency", k, 2);
        chk("first_beat_data", last_data, 32'h1);
        got = 32'(last_beat);
        repeat (15) begin
            cycle();
            got += 32'(last_beat);
        end
        chk("stream16_no_gap", got, 16);
        cycle();
        chk("words_out_16", words_out, 16);

        // Backpressure: only DEPTH reads go out and the head word holds.
        m_ready = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) push_word(32'(i));
        got = 0;
        repeat (20) begin
            cycle();
            got += 32'(last_rd);
        end
        chk("bp_reads_issued", got, 3);
        chk("bp_level", level, 3);
        chk("bp_m_data", m_data, 32'h1);
        chk("bp_m_valid", m_valid, 1);
        m_ready = 1'b1;
        got = 0;
        repeat (8) begin
            cycle();
            got += 32'(last_beat);
        end
        chk("bp_drain_no_gap", got, 8);
        cycle();
        chk("words_out_24", words_out, 24);

        // Random data and random ready.
        void'($urandom(7));
        for (int unsigned i = 0; i < 200; i++) push_word($urandom);
        k = 0;
        while (words_out != 16'd224 && k < 3000) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle();
            k++;
        end
        chk("random_words_out", words_out, 224);

        // Flush while a read is outstanding.
        m_ready = 1'b0;
        for (int unsigned i = 0; i < 10; i++) push_word(32'hA0 + 32'(i));
        repeat (6) cycle();
        chk("fl_level_full", level, 3);
        m_ready = 1'b1;
        cycle();
        cycle();
        m_ready = 1'b0;
        flush   = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_in_flight", 32'(prev_rd), 1);
        chk("fl_valid_after", m_valid, 0);
        chk("fl_level_after", level, 0);
        chk("fl_words_out", words_out, 226);
        m_ready = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!last_beat && k < 20);
        chk("fl_resume_word", last_data, 32'hA4);
        k = 0;
        while (words_out != 16'd232 && k < 100) begin
            cycle();
            k++;
        end
        chk("fl_words_out_end", words_out, 232);

        // DEPTH=2 instance: all words delivered, 4-bit counter wrapped twice.
        k = 0;
        while (exp_cnt2 < N2 && k < 200) begin
            cycle();
            k++;
        end
        repeat (2) cycle();
        chk("d2_delivered", exp_cnt2, N2);
        chk("d2_words_wrapped", words2, 0);
        chk("d2_level_empty", level2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
